// File: rtl/lc3_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC3 data-memory access stage:
//   - mem_state bus encodings (also consumed by the memaccess stage)
//   - memory-op codes as issued by the control unit
//   - sequencer state enumeration
//   - small decode helpers for the op codes
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

    // mem_state encodings driven towards the memaccess stage
    localparam logic [1:0] MS_DRD  = 2'd0;  // data read
    localparam logic [1:0] MS_PRD  = 2'd1;  // pointer read (indirect first phase)
    localparam logic [1:0] MS_DWR  = 2'd2;  // data write
    localparam logic [1:0] MS_IDLE = 2'd3;  // bus released

    // Memory op codes on req_op
    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_STORE     = 2'd1,
        OP_LOAD_IND  = 2'd2,
        OP_STORE_IND = 2'd3
    } mem_op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PTR_RD  = 3'd1,
        ST_DATA_RD = 3'd2,
        ST_DATA_WR = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // Indirect ops carry the pointer phase; encoded in the op MSB
    function automatic logic op_is_ind(input mem_op_e op);
        return op[1];
    endfunction

    // Loads have LSB clear
    function automatic logic op_is_load(input mem_op_e op);
        return ~op[0];
    endfunction

    // First access phase entered when an op is accepted
    function automatic seq_state_e first_phase(input mem_op_e op);
        seq_state_e st;
        case (op)
            OP_LOAD:      st = ST_DATA_RD;
            OP_STORE:     st = ST_DATA_WR;
            OP_LOAD_IND:  st = ST_PTR_RD;
            OP_STORE_IND: st = ST_PTR_RD;
            default:      st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_sequencer_if
// Bundles the op-issue handshake and the memaccess-stage signals of the
// LC3 memory sequencer.
//   master : issuer/environment side (drives req_valid, req_op, memout)
//   slave  : sequencer side (drives req_ready, mem_state, M_Control, busy,
//            done, load_valid, load_data, ptr_q)
// ---------------------------------------------------------------------------
interface lc3_mem_sequencer_if;
    import lc3_mem_pkg::*;

    logic        req_valid;
    mem_op_e     req_op;
    logic        req_ready;
    logic [15:0] memout;
    logic [1:0]  mem_state;
    logic        M_Control;
    logic        busy;
    logic        done;
    logic        load_valid;
    logic [15:0] load_data;
    logic [15:0] ptr_q;

    modport master (
        output req_valid, req_op, memout,
        input  req_ready, mem_state, M_Control, busy, done,
               load_valid, load_data, ptr_q
    );

    modport slave (
        input  req_valid, req_op, memout,
        output req_ready, mem_state, M_Control, busy, done,
               load_valid, load_data, ptr_q
    );

endinterface

// File: rtl/lc3_mem_sequencer.sv
// ---------------------------------------------------------------------------
// lc3_mem_sequencer
// Steps the LC3 memaccess stage through its mem_state / M_Control phases
// for LOAD, STORE, LOAD_IND and STORE_IND. Each access phase is held for
// ACC_CYCLES cycles. Load data and the indirect pointer are captured from
// memout on the last cycle of their phase.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave modport of lc3_mem_sequencer_if (handshake, phase
//           outputs, captured data)
// All outputs are flops; their next values are decoded from the next state,
// so there is no combinational path from req_* to any output.
// ---------------------------------------------------------------------------
module lc3_mem_sequencer
    import lc3_mem_pkg::*;
#(
    parameter int ACC_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_mem_sequencer_if.slave   bus
);

    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ind_q, ind_d;
    logic              load_q, load_d;
    logic [15:0]       ptr_cap_q, ptr_cap_d;
    logic [15:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              m_control_q, m_control_d;
    logic [1:0]        mem_state_q, mem_state_d;

    logic              accept_s;
    logic              phase_last_s;

    // ready is a flop, so accept depends only on req_valid and registered state
    assign accept_s     = bus.req_valid & ready_q;
    assign phase_last_s = (cnt_q == CNT_LAST);

    // Next-state, wait counter and capture logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        ind_d        = ind_q;
        load_d       = load_q;
        ptr_cap_d    = ptr_cap_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d = '0;
                if (accept_s) begin
                    // Back-to-back accept from DONE skips the idle bubble
                    state_d = first_phase(bus.req_op);
                    ind_d   = op_is_ind(bus.req_op);
                    load_d  = op_is_load(bus.req_op);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PTR_RD: begin
                if (phase_last_s) begin
                    ptr_cap_d = bus.memout;
                    state_d   = load_q ? ST_DATA_RD : ST_DATA_WR;
                    cnt_d     = '0;
                end else begin
                    state_d   = ST_PTR_RD;
                end
            end
            ST_DATA_RD: begin
                if (phase_last_s) begin
                    load_data_d  = bus.memout;
                    load_valid_d = 1'b1;
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                end else begin
                    state_d      = ST_DATA_RD;
                end
            end
            ST_DATA_WR: begin
                if (phase_last_s) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DATA_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the outputs themselves are flops
    always_comb begin
        mem_state_d = MS_IDLE;
        m_control_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_PTR_RD: begin
                mem_state_d = MS_PRD;
                busy_d      = 1'b1;
            end
            ST_DATA_RD: begin
                mem_state_d = MS_DRD;
                m_control_d = ind_d;
                busy_d      = 1'b1;
            end
            ST_DATA_WR: begin
                mem_state_d = MS_DWR;
                m_control_d = ind_d;
                busy_d      = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
            default: begin
                mem_state_d = MS_IDLE;
            end
        endcase
    end

    // State, counter, captured data and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ind_q        <= 1'b0;
            load_q       <= 1'b0;
            ptr_cap_q    <= 16'h0000;
            load_data_q  <= 16'h0000;
            load_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            m_control_q  <= 1'b0;
            mem_state_q  <= MS_IDLE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ind_q        <= ind_d;
            load_q       <= load_d;
            ptr_cap_q    <= ptr_cap_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            m_control_q  <= m_control_d;
            mem_state_q  <= mem_state_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.mem_state  = mem_state_q;
    assign bus.M_Control  = m_control_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_valid = load_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.ptr_q      = ptr_cap_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_sequencer
// Two sequencers (ACC_CYCLES=1 and ACC_CYCLES=3) on a shared clock/reset,
// each with a tiny memaccess model: address = M_Control ? ptr_q : M_Addr,
// async read into memout, write on clock edges while mem_state is data-write.
// ---------------------------------------------------------------------------
module tb_lc3_mem_sequencer;
    import lc3_mem_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] m_addr0, m_data0, m_addr1, m_data1;
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem [0:65535];
    logic [15:0] addr0_s, addr1_s;

    int total = 0;
    int bad   = 0;

    lc3_mem_sequencer_if if0 ();
    lc3_mem_sequencer_if if1 ();

    lc3_mem_sequencer #(.ACC_CYCLES(1)) u0 (.clock(clock), .reset(reset), .bus(if0));
    lc3_mem_sequencer #(.ACC_CYCLES(3)) u1 (.clock(clock), .reset(reset), .bus(if1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign addr0_s   = if0.M_Control ? if0.ptr_q : m_addr0;
    assign addr1_s   = if1.M_Control ? if1.ptr_q : m_addr1;
    assign if0.memout = mem[addr0_s];
    assign if1.memout = mem[addr1_s];

    // Memory model writes: preload port plus the two data-write phases
    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (if0.mem_state == MS_DWR) mem[addr0_s] <= m_data0;
        if (if1.mem_state == MS_DWR) mem[addr1_s] <= m_data1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    logic [13:0] ms_seq;
    logic [6:0]  mc_seq, dn_seq;

    initial begin
        reset = 1'b0;
        pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 16'h0000;
        m_addr0 = 16'h0000; m_data0 = 16'h0000;
        m_addr1 = 16'h0000; m_data1 = 16'h0000;
        if0.req_valid = 1'b0; if0.req_op = OP_LOAD;
        if1.req_valid = 1'b0; if1.req_op = OP_LOAD;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_mem_state", 16'(if0.mem_state), 16'h0003);
        chk("rst_busy",      16'(if0.busy),      16'h0000);
        chk("rst_done",      16'(if0.done),      16'h0000);
        chk("rst_load_valid",16'(if0.load_valid),16'h0000);
        chk("rst_load_data", if0.load_data,      16'h0000);
        chk("rst_ptr",       if0.ptr_q,          16'h0000);
        chk("rst_mcontrol",  16'(if0.M_Control), 16'h0000);
        reset = 1'b1;

        preload(16'h3000, 16'hBEEF);
        preload(16'h3002, 16'h4000);
        preload(16'h4000, 16'hCAFE);
        preload(16'h3003, 16'h5000);

        // 1: LOAD 0x3000
        @(negedge clock);
        chk("idle_ready", 16'(if0.req_ready), 16'h0001);
        m_addr0 = 16'h3000; if0.req_op = OP_LOAD; if0.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.req_valid = 1'b0;
        chk("ld_ms_phase", 16'(if0.mem_state), 16'h0000);
        chk("ld_busy",     16'(if0.busy),      16'h0001);
        chk("ld_ready",    16'(if0.req_ready), 16'h0000);
        chk("ld_done_early",16'(if0.done),     16'h0000);
        @(negedge clock);
        chk("ld_done",     16'(if0.done),       16'h0001);
        chk("ld_lvalid",   16'(if0.load_valid), 16'h0001);
        chk("ld_data",     if0.load_data,       16'hBEEF);
        chk("ld_ms_done",  16'(if0.mem_state),  16'h0003);
        @(negedge clock);
        chk("ld_done_pulse",  16'(if0.done),       16'h0000);
        chk("ld_lvalid_pulse",16'(if0.load_valid), 16'h0000);
        chk("ld_data_hold",   if0.load_data,       16'hBEEF);

        // 2: STORE 0x3001 <= 0x1234
        m_addr0 = 16'h3001; m_data0 = 16'h1234; if0.req_op = OP_STORE; if0.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.req_valid = 1'b0;
        chk("st_ms_phase", 16'(if0.mem_state), 16'h0002);
        chk("st_mcontrol", 16'(if0.M_Control), 16'h0000);
        @(negedge clock);
        chk("st_done",     16'(if0.done),       16'h0001);
        chk("st_lvalid",   16'(if0.load_valid), 16'h0000);
        chk("st_ld_hold",  if0.load_data,       16'hBEEF);
        chk("st_mem",      mem[16'h3001],       16'h1234);

        // 3: LOAD_IND via 0x3002 -> 0x4000
        @(negedge clock);
        m_addr0 = 16'h3002; if0.req_op = OP_LOAD_IND; if0.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.req_valid = 1'b0;
        chk("li_ms_ptr",   16'(if0.mem_state), 16'h0001);
        chk("li_mc_ptr",   16'(if0.M_Control), 16'h0000);
        @(negedge clock);
        chk("li_ms_data",  16'(if0.mem_state), 16'h0000);
        chk("li_mc_data",  16'(if0.M_Control), 16'h0001);
        chk("li_ptr",      if0.ptr_q,          16'h4000);
        chk("li_done_early",16'(if0.done),     16'h0000);
        @(negedge clock);
        chk("li_done",     16'(if0.done),       16'h0001);
        chk("li_lvalid",   16'(if0.load_valid), 16'h0001);
        chk("li_data",     if0.load_data,       16'hCAFE);

        // 4: STORE_IND on the ACC_CYCLES=3 instance, 7-cycle trace
        m_addr1 = 16'h3003; m_data1 = 16'h0A0A; if1.req_op = OP_STORE_IND; if1.req_valid = 1'b1;
        ms_seq = '0; mc_seq = '0; dn_seq = '0;
        @(posedge clock);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if1.req_valid = 1'b0;
            ms_seq = {ms_seq[11:0], if1.mem_state};
            mc_seq = {mc_seq[5:0], if1.M_Control};
            dn_seq = {dn_seq[5:0], if1.done};
            if (i < 6) @(posedge clock);
        end
        chk("si_ms_trace", {2'b00, ms_seq}, 16'b00_01_01_01_10_10_10_11);
        chk("si_mc_trace", {9'd0, mc_seq},  16'b0000000_0001110);
        chk("si_done_lat7",{9'd0, dn_seq},  16'b0000000_0000001);
        chk("si_ptr",      if1.ptr_q,       16'h5000);
        chk("si_mem",      mem[16'h5000],   16'h0A0A);

        // 5: LOAD accepted in the DONE cycle of a STORE
        @(negedge clock);
        m_addr0 = 16'h3005; m_data0 = 16'h5555; if0.req_op = OP_STORE; if0.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if0.req_op = OP_LOAD;  // next op held by the issuer during busy
        chk("b2b_ms_wr",   16'(if0.mem_state), 16'h0002);
        chk("b2b_ready_busy",16'(if0.req_ready),16'h0000);
        @(negedge clock);
        chk("b2b_ms_done", 16'(if0.mem_state), 16'h0003);
        chk("b2b_done_st", 16'(if0.done),      16'h0001);
        chk("b2b_ready_done",16'(if0.req_ready),16'h0001);
        @(negedge clock);
        if0.req_valid = 1'b0;
        chk("b2b_ms_rd",   16'(if0.mem_state), 16'h0000);
        chk("b2b_busy",    16'(if0.busy),      16'h0001);
        @(negedge clock);
        chk("b2b_done_ld", 16'(if0.done),      16'h0001);
        chk("b2b_lvalid",  16'(if0.load_valid),16'h0001);
        chk("b2b_data",    if0.load_data,      16'h5555);
        @(negedge clock);
        chk("b2b_idle_ms", 16'(if0.mem_state), 16'h0003);
        chk("b2b_no_dbl",  16'(if0.done),      16'h0000);

        // 6: reset asserted during PTR_RD of a LOAD_IND
        m_addr0 = 16'h3002; if0.req_op = OP_LOAD_IND; if0.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rr_ms_ptr",   16'(if0.mem_state), 16'h0001);
        if0.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rr_ms",       16'(if0.mem_state), 16'h0003);
        chk("rr_busy",     16'(if0.busy),      16'h0000);
        chk("rr_done",     16'(if0.done),      16'h0000);
        chk("rr_lvalid",   16'(if0.load_valid),16'h0000);
        chk("rr_data",     if0.load_data,      16'h0000);
        chk("rr_ptr",      if0.ptr_q,          16'h0000);
        chk("rr_mem",      mem[16'h4000],      16'hCAFE);
        reset = 1'b1;
        @(negedge clock);
        chk("rr_done_after",16'(if0.done),     16'h0000);
        chk("rr_ready",    16'(if0.req_ready), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
